// File: rtl/adc_scan_sequencer.sv
// Round-robin scan sequencer for a parallel ADC behind an analog mux.
// BUSY-driven conversion timing with timeout; samples leave via a 1-entry buffer.
module adc_scan_sequencer #(
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 4,
  parameter int BASE_PERIOD = 200000,
  parameter int SETTLE_CYC  = 4,
  parameter int CONVST_CYC  = 2,
  parameter int RD_CYC      = 3,
  parameter int TIMEOUT_CYC = 1000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              enable,
  input  logic [2:0]        rateSel,
  input  logic [NUM_CH-1:0] chMask,
  input  logic              adcBusy,
  input  logic [DATA_W-1:0] D,
  output logic              CS,
  output logic              RD,
  output logic              CONVST,
  output logic [CH_W-1:0]   chSel,
  output logic [DATA_W-1:0] sampleData,
  output logic [CH_W-1:0]   sampleCh,
  output logic              sampleValid,
  input  logic              sampleReady,
  output logic              overrun,
  output logic              missedTick,
  output logic              timeout
);

  localparam int PW = $clog2(BASE_PERIOD + 1);
  localparam int CW = 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] BASE_L   = PW'(BASE_PERIOD);
  localparam logic [CW-1:0] SETTLE_L = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CONV_L   = CW'(CONVST_CYC - 1);
  localparam logic [CW-1:0] RD_L     = CW'(RD_CYC - 1);
  localparam logic [TW-1:0] TO_L     = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, CONV, WAIT_HI, WAIT_LO, READ, LOAD
  } state_t;

  state_t state, stateNxt;

  logic            busyS1, busyS2;
  logic [PW-1:0]   perCnt, periodLen;
  logic            tick;
  logic [CW-1:0]   cycCnt, cycCntNxt;
  logic [TW-1:0]   toCnt, toCntNxt;
  logic            toFire;
  logic [CH_W-1:0] lastCh, pickCh;
  logic            pickOk;
  logic [DATA_W-1:0] dataCap;
  logic            csNxt, convstNxt;

  assign periodLen = BASE_L >> rateSel;
  // >= so a shortened period after a rateSel change still wraps at once
  assign tick = enable && (periodLen != '0)
             && (perCnt >= periodLen - PW'(1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      perCnt <= '0;
      busyS1 <= 1'b0;
      busyS2 <= 1'b0;
    end else begin
      busyS1 <= adcBusy;
      busyS2 <= busyS1;
      if (!enable || tick) perCnt <= '0;
      else                 perCnt <= perCnt + PW'(1);
    end
  end

  always_comb begin
    pickOk = 1'b0;
    pickCh = lastCh;
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(lastCh) + k) % NUM_CH;
      if (!pickOk && chMask[CH_W'(idx)]) begin
        pickOk = 1'b1;
        pickCh = CH_W'(idx);
      end
    end
  end

  always_comb begin
    stateNxt  = state;
    cycCntNxt = cycCnt + CW'(1);
    toCntNxt  = toCnt;
    toFire    = 1'b0;
    unique case (state)
      IDLE: begin
        cycCntNxt = '0;
        if (tick && pickOk) stateNxt = SETTLE;
      end
      SETTLE: if (cycCnt == SETTLE_L) begin
        stateNxt  = CONV;
        cycCntNxt = '0;
      end
      CONV: if (cycCnt == CONV_L) begin
        stateNxt  = WAIT_HI;
        cycCntNxt = '0;
        toCntNxt  = '0;
      end
      WAIT_HI: begin
        cycCntNxt = '0;
        toCntNxt  = toCnt + TW'(1);
        if (busyS2) stateNxt = WAIT_LO;
        else if (toCnt >= TO_L) begin
          stateNxt = IDLE;
          toFire   = 1'b1;
        end
      end
      WAIT_LO: begin
        cycCntNxt = '0;
        toCntNxt  = toCnt + TW'(1);
        if (!busyS2) stateNxt = READ;
        else if (toCnt >= TO_L) begin
          stateNxt = IDLE;
          toFire   = 1'b1;
        end
      end
      READ: if (cycCnt == RD_L) stateNxt = LOAD;
      LOAD: stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    csNxt     = (stateNxt != READ);
    convstNxt = (stateNxt != CONV);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      cycCnt      <= '0;
      toCnt       <= '0;
      CS          <= 1'b1;
      RD          <= 1'b1;
      CONVST      <= 1'b1;
      chSel       <= '0;
      lastCh      <= CH_W'(NUM_CH - 1);
      dataCap     <= '0;
      sampleData  <= '0;
      sampleCh    <= '0;
      sampleValid <= 1'b0;
      overrun     <= 1'b0;
      missedTick  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state  <= stateNxt;
      cycCnt <= cycCntNxt;
      toCnt  <= toCntNxt;
      CS     <= csNxt;
      RD     <= csNxt;
      CONVST <= convstNxt;
      if (state == IDLE && tick && pickOk) begin
        chSel  <= pickCh;
        lastCh <= pickCh;
      end
      if (state == READ && cycCnt == RD_L) dataCap <= D;
      // a handshake in the LOAD cycle frees the slot, so no overrun
      if (state == LOAD) begin
        sampleData  <= dataCap;
        sampleCh    <= chSel;
        sampleValid <= 1'b1;
        if (sampleValid && !sampleReady) overrun <= 1'b1;
      end else if (sampleValid && sampleReady) begin
        sampleValid <= 1'b0;
      end
      if (tick && state != IDLE) missedTick <= 1'b1;
      if (toFire) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a BUSY-pulse ADC model.
// Samples outputs on the falling clock edge.
module tb_adc_scan_sequencer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] rateSel = 3'd0;
  logic [3:0] chMask = 4'd0;
  logic       adcBusy = 1'b0;
  logic [7:0] D;
  logic       CS, RD, CONVST;
  logic [1:0] chSel, sampleCh;
  logic [7:0] sampleData;
  logic       sampleValid;
  logic       sampleReady = 1'b1;
  logic       overrun, missedTick, timeout;

  int total = 0;
  int bad = 0;
  int busyLen = 10;
  int cyc = 0;

  always #5 Clk = ~Clk;

  function automatic logic [7:0] expD(int ch);
    return 8'(8'h50 + ch * 17);
  endfunction

  assign D = expD(int'(chSel));

  adc_scan_sequencer #(
    .DATA_W(8), .NUM_CH(4), .BASE_PERIOD(100), .SETTLE_CYC(4),
    .CONVST_CYC(2), .RD_CYC(3), .TIMEOUT_CYC(50)
  ) dut (
    .Clk(Clk), .Rst(Rst), .enable(enable), .rateSel(rateSel),
    .chMask(chMask), .adcBusy(adcBusy), .D(D), .CS(CS), .RD(RD),
    .CONVST(CONVST), .chSel(chSel), .sampleData(sampleData),
    .sampleCh(sampleCh), .sampleValid(sampleValid),
    .sampleReady(sampleReady), .overrun(overrun),
    .missedTick(missedTick), .timeout(timeout)
  );

  // ADC model: BUSY high for busyLen cycles after CONVST returns high
  initial forever begin
    @(negedge CONVST);
    @(posedge CONVST);
    if (busyLen > 0) begin
      #1 adcBusy = 1'b1;
      repeat (busyLen) @(posedge Clk);
      #1 adcBusy = 1'b0;
    end
  end

  typedef struct {
    int ch;
    int data;
    int cyc;
  } smp_t;
  smp_t capQ[$];

  int convRun = 0, csRun = 0, lastConvRun = 0, lastCsRun = 0;
  int csRdDiff = 0, convInCs = 0, chStab = 0, stabAtConv = -1;
  int convRiseCyc = 0, toRiseCyc = 0;
  logic prevConv = 1'b1, prevTo = 1'b0;
  logic [1:0] prevCh = 2'd0;

  always @(negedge Clk) begin
    cyc++;
    if (sampleValid && sampleReady)
      capQ.push_back('{int'(sampleCh), int'(sampleData), cyc});
    if (CS !== RD) csRdDiff++;
    if (!CONVST && !CS) convInCs++;
    chStab = (chSel != prevCh) ? 0 : chStab + 1;
    prevCh = chSel;
    if (!CONVST && prevConv) stabAtConv = chStab;
    if (CONVST && !prevConv) convRiseCyc = cyc;
    if (timeout && !prevTo) toRiseCyc = cyc;
    prevConv = CONVST;
    prevTo = timeout;
    if (!CONVST) convRun++;
    else if (convRun != 0) begin
      lastConvRun = convRun;
      convRun = 0;
    end
    if (!CS) csRun++;
    else if (csRun != 0) begin
      lastCsRun = csRun;
      csRun = 0;
    end
  end

  task automatic checkEq(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic doReset();
    enable = 1'b0;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    capQ.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int expCh[5];
    expCh = '{0, 1, 3, 0, 1};
    repeat (3) @(negedge Clk);
    checkEq("rstCS", CS, 1);
    checkEq("rstRD", RD, 1);
    checkEq("rstCONVST", CONVST, 1);
    checkEq("rstValid", sampleValid, 0);
    checkEq("rstFlags", {overrun, missedTick, timeout}, 0);
    checkEq("rstChSel", chSel, 0);
    Rst = 1'b0;

    // round robin over mask 1011
    chMask = 4'b1011;
    busyLen = 10;
    capQ.delete();
    enable = 1'b1;
    for (int i = 0; i < 700 && capQ.size() < 5; i++) @(negedge Clk);
    checkEq("rrCount", capQ.size(), 5);
    if (capQ.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checkEq($sformatf("rrCh%0d", i), capQ[i].ch, expCh[i]);
        checkEq($sformatf("rrData%0d", i), capQ[i].data,
                int'(expD(expCh[i])));
        if (i > 0)
          checkEq($sformatf("rrPeriod%0d", i),
                  capQ[i].cyc - capQ[i-1].cyc, 100);
      end
    end
    checkEq("convLow", lastConvRun, 2);
    checkEq("csLow", lastCsRun, 3);
    checkEq("csRdSync", csRdDiff, 0);
    checkEq("convInCs", convInCs, 0);
    checkEq("chStable", int'(stabAtConv >= 4), 1);
    checkEq("rrNoMiss", missedTick, 0);
    checkEq("rrNoOverrun", overrun, 0);

    // fast rate with a long BUSY: second tick lands mid-sequence
    doReset();
    chMask = 4'b0001;
    rateSel = 3'd2;
    busyLen = 20;
    enable = 1'b1;
    repeat (80) @(negedge Clk);
    checkEq("rateMissed", missedTick, 1);
    checkEq("rateNoTimeout", timeout, 0);

    // BUSY stuck low
    doReset();
    rateSel = 3'd0;
    busyLen = 0;
    enable = 1'b1;
    for (int i = 0; i < 300 && !timeout; i++) @(negedge Clk);
    @(negedge Clk);
    checkEq("toSet", timeout, 1);
    checkEq("toLatency", toRiseCyc - convRiseCyc, 50);
    checkEq("toNoSample", capQ.size(), 0);
    checkEq("toNoValid", sampleValid, 0);
    busyLen = 10;
    for (int i = 0; i < 200 && capQ.size() == 0; i++) @(negedge Clk);
    checkEq("toRecover", capQ.size(), 1);

    // backpressure over two conversions
    doReset();
    chMask = 4'b0011;
    sampleReady = 1'b0;
    enable = 1'b1;
    repeat (150) @(negedge Clk);
    checkEq("bpFirstValid", sampleValid, 1);
    checkEq("bpNoOverrunYet", overrun, 0);
    checkEq("bpFirstCh", sampleCh, 0);
    repeat (90) @(negedge Clk);
    checkEq("bpOverrun", overrun, 1);
    checkEq("bpCh", sampleCh, 1);
    checkEq("bpData", sampleData, int'(expD(1)));
    checkEq("bpValid", sampleValid, 1);
    sampleReady = 1'b1;
    @(negedge Clk);
    checkEq("bpDrop", sampleValid, 0);

    // enable dropped during SETTLE
    doReset();
    chMask = 4'b0010;
    enable = 1'b1;
    for (int i = 0; i < 200 && chSel != 2'd1; i++) @(negedge Clk);
    enable = 1'b0;
    checkEq("enSettle", chSel, 1);
    repeat (300) @(negedge Clk);
    checkEq("enOffCount", capQ.size(), 1);
    if (capQ.size() == 1) begin
      checkEq("enOffCh", capQ[0].ch, 1);
      checkEq("enOffData", capQ[0].data, int'(expD(1)));
    end
    checkEq("enOffConv", lastConvRun, 2);

    // empty mask ignores ticks
    doReset();
    chMask = 4'b0000;
    enable = 1'b1;
    repeat (250) @(negedge Clk);
    checkEq("emptyCount", capQ.size(), 0);
    checkEq("emptyMiss", missedTick, 0);
    checkEq("emptyCONVST", CONVST, 1);

    // async reset during READ
    doReset();
    chMask = 4'b0001;
    enable = 1'b1;
    for (int i = 0; i < 200 && CS !== 1'b0; i++) @(negedge Clk);
    checkEq("rdSeen", RD, 0);
    #1 Rst = 1'b1;
    #1;
    checkEq("rdRstCS", CS, 1);
    checkEq("rdRstRD", RD, 1);
    checkEq("rdRstCONVST", CONVST, 1);
    checkEq("rdRstValid", sampleValid, 0);
    @(negedge Clk);
    Rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
